seq_scan_arbiter: RTL and testbench

//   Shares one Moore serial pattern detector between NUM_REQ requesters. Each requester

---
 rtl/seq_scan_pkg.sv | 19 +
 rtl/seq_detect_core.sv | 57 +++++
 rtl/seq_scan_arbiter.sv | 134 +++++++++++++
 tb/tb_seq_scan_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared definitions for the scan arbiter: FSM encodings, default pattern
// and an elaboration-time clog2 helper.
package seq_scan_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_detect_core.sv
// Moore serial pattern detector, MSB of PATTERN received first, overlapping.
// State = number of pattern bits currently matched (0..PAT_W).
module seq_detect_core
    import seq_scan_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic sequence_in,
    output logic detector_out
);

    localparam int          ST_W    = clog2(PAT_W + 1);
    localparam logic [31:0] PAT_EXT = 32'(PATTERN);

    logic [ST_W-1:0] st_q;
    logic [ST_W-1:0] st_d;

    // Longest prefix of PATTERN that is a suffix of (matched prefix + new bit).
    function automatic int kmp_next(input int s, input logic b);
        int   res;
        int   idx;
        logic ok;
        logic sb;
        res = 0;
        for (int k = 1; k <= PAT_W; k++) begin
            if (k <= s + 1) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    idx = s + 1 - k + j;
                    sb  = (idx == s) ? b : PAT_EXT[5'(PAT_W - 1 - idx)];
                    if (sb != PAT_EXT[5'(PAT_W - 1 - j)]) ok = 1'b0;
                end
                if (ok) res = k;
            end
        end
        return res;
    endfunction

    always_comb begin
        st_d = st_q;
        if (enable) st_d = ST_W'(kmp_next(int'(st_q), sequence_in));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     st_q <= '0;
        else if (clear) st_q <= '0;
        else            st_q <= st_d;
    end

    assign detector_out = (st_q == ST_W'(PAT_W));

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter sharing one serial pattern detector between NUM_REQ clients;
// the granted frame is shifted MSB-first and overlapping hits are counted.
module seq_scan_arbiter
    import seq_scan_pkg::*;
#(
    parameter int               NUM_REQ = 4,
    parameter int               FRAME_W = 8,
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               CNT_W   = clog2(FRAME_W + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*FRAME_W-1:0]   frame_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         busy,
    output logic                         done,
    output logic [clog2(NUM_REQ)-1:0]    done_id,
    output logic [CNT_W-1:0]             hit_count,
    output logic                         sequence_out,
    output logic                         detector_hit
);

    localparam int ID_W = clog2(NUM_REQ);

    logic [1:0]         state;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bits_left;
    logic [ID_W-1:0]    rr;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    cand;
    logic               found;
    logic               det_clear;
    logic               det_enable;
    logic [FRAME_W-1:0] frames [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_frames
        assign frames[gi] = frame_data[gi*FRAME_W +: FRAME_W];
    end

    // First requester after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(rr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign det_clear  = (state == IDLE);
    assign det_enable = (state == SHIFT);

    seq_detect_core #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_detect (
        .clock        (clock),
        .reset        (reset),
        .clear        (det_clear),
        .enable       (det_enable),
        .sequence_in  (sequence_out),
        .detector_out (detector_hit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            gnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_id      <= '0;
            hit_count    <= '0;
            sequence_out <= 1'b0;
            shreg        <= '0;
            bits_left    <= '0;
            rr           <= ID_W'(NUM_REQ - 1);
            winner       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state        <= SHIFT;
                        gnt          <= NUM_REQ'(1) << pick;
                        busy         <= 1'b1;
                        winner       <= pick;
                        rr           <= pick;
                        hit_count    <= '0;
                        sequence_out <= frames[pick][FRAME_W-1];
                        shreg        <= frames[pick] << 1;
                        bits_left    <= CNT_W'(FRAME_W - 1);
                    end
                end
                SHIFT: begin
                    if (detector_hit) hit_count <= hit_count + CNT_W'(1);
                    shreg <= shreg << 1;
                    if (bits_left == '0) begin
                        state        <= DRAIN;
                        sequence_out <= 1'b0;
                    end else begin
                        bits_left    <= bits_left - CNT_W'(1);
                        sequence_out <= shreg[FRAME_W-1];
                    end
                end
                DRAIN: begin
                    // Hit produced by the final frame bit shows up here.
                    if (detector_hit) hit_count <= hit_count + CNT_W'(1);
                    state   <= DONE;
                    gnt     <= '0;
                    done    <= 1'b1;
                    done_id <= winner;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    gnt          <= '0;
                    busy         <= 1'b0;
                    sequence_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed bench for seq_scan_arbiter with a scoreboard of expected scan results.
module tb_seq_scan_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] frame_data;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  hit_count;
    logic        sequence_out;
    logic        detector_hit;

    typedef struct {
        int         id;
        logic [7:0] frame;
        int         hits;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   last_g  = 0;

    seq_scan_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .frame_data   (frame_data),
        .gnt          (gnt),
        .busy         (busy),
        .done         (done),
        .done_id      (done_id),
        .hit_count    (hit_count),
        .sequence_out (sequence_out),
        .detector_hit (detector_hit)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Overlapping 1011 windows, MSB first, within one frame only.
    function automatic int model_hits(input logic [7:0] f);
        int         h;
        logic [3:0] w;
        h = 0;
        for (int i = 0; i <= 4; i++) begin
            w = 4'(f >> (4 - i));
            if (w == 4'b1011) h++;
        end
        return h;
    endfunction

    task automatic push(input int id, input logic [7:0] f);
        exp_t e;
        e.id    = id;
        e.frame = f;
        e.hits  = model_hits(f);
        sb.push_back(e);
    endtask

    task automatic run_scan(input int mid_k, input logic [3:0] mid_req,
                            input logic [7:0] mid_f0, input bit chk_gap);
        exp_t       e;
        int         n;
        int         g;
        logic [3:0] eg;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e  = sb[0];
        eg = 4'b0001 << e.id;
        n  = 0;
        do begin
            @(negedge clock);
            n++;
        end while (gnt == 4'd0 && n < 40);
        chk("gnt_start", 32'(gnt), 32'(eg));
        if (gnt == 4'd0) begin
            void'(sb.pop_front());
            return;
        end
        g = cyc;
        if (chk_gap) chk("grant_gap", 32'(g - last_g), 32'd11);
        last_g = g;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            chk("seq_bit", 32'(sequence_out), 32'(e.frame[7-k]));
            chk("gnt_hold", 32'(gnt), 32'(eg));
            if (k == mid_k) begin
                req              = mid_req;
                frame_data[7:0]  = mid_f0;
            end
        end
        @(negedge clock);
        chk("drain_gnt", 32'(gnt), 32'(eg));
        chk("drain_seq", 32'(sequence_out), 32'd0);
        chk("drain_done", 32'(done), 32'd0);
        @(negedge clock);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_latency", 32'(cyc - g), 32'd9);
        chk("done_gnt", 32'(gnt), 32'd0);
        chk("done_id", 32'(done_id), 32'(e.id));
        chk("hit_count", 32'(hit_count), 32'(e.hits));
        void'(sb.pop_front());
        @(negedge clock);
        chk("done_cleared", 32'(done), 32'd0);
        chk("hit_held", 32'(hit_count), 32'(e.hits));
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int dcnt;
        reset      = 1'b0;
        req        = 4'd0;
        frame_data = 32'd0;
        repeat (2) @(negedge clock);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_seq", 32'(sequence_out), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // single client
        push(0, 8'hBB);
        frame_data[7:0] = 8'hBB;
        req = 4'b0001;
        run_scan(-1, 4'b0001, 8'hBB, 1'b0);

        // overlap and non-overlap frames, back to back
        push(0, 8'h5B); push(0, 8'h2D); push(0, 8'h00);
        frame_data[7:0] = 8'h5B;
        run_scan(-1, 4'b0001, 8'h5B, 1'b1);
        frame_data[7:0] = 8'h2D;
        run_scan(-1, 4'b0001, 8'h2D, 1'b1);
        frame_data[7:0] = 8'h00;
        run_scan(-1, 4'b0001, 8'h00, 1'b1);
        req = 4'd0;

        // round robin from a fresh reset
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        frame_data = {8'h00, 8'h2D, 8'h5B, 8'hBB};
        push(0, 8'hBB); push(1, 8'h5B); push(2, 8'h2D); push(3, 8'h00); push(0, 8'hBB);
        req = 4'hF;
        run_scan(-1, 4'hF, 8'hBB, 1'b0);
        for (int i = 0; i < 4; i++) run_scan(-1, 4'hF, 8'hBB, 1'b1);
        req = 4'd0;

        // late request and mid-scan data change
        repeat (3) @(negedge clock);
        frame_data[7:0] = 8'h0B;
        push(0, 8'h0B); push(2, 8'h2D);
        req = 4'b0001;
        run_scan(3, 4'b0100, 8'hFF, 1'b0);
        run_scan(-1, 4'b0100, 8'hFF, 1'b1);
        req = 4'd0;

        // reset during SHIFT
        repeat (3) @(negedge clock);
        frame_data[7:0] = 8'hBB;
        req = 4'b0001;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (gnt == 4'd0 && n < 40);
        chk("abort_gnt", 32'(gnt), 32'd1);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        req   = 4'd0;
        #1;
        chk("abort_gnt_clr", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_seq", 32'(sequence_out), 32'd0);
        chk("abort_hits", 32'(hit_count), 32'd0);
        chk("abort_done_id", 32'(done_id), 32'd0);
        chk("abort_det", 32'(detector_hit), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        dcnt = 0;
        repeat (15) begin
            @(negedge clock);
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        push(0, 8'hBB);
        req = 4'b0001;
        run_scan(-1, 4'b0001, 8'hBB, 1'b0);
        req = 4'd0;

        // back-to-back frames, no carry-over
        repeat (2) @(negedge clock);
        frame_data[7:0] = 8'h0B;
        push(0, 8'h0B); push(0, 8'h80);
        req = 4'b0001;
        run_scan(2, 4'b0001, 8'h80, 1'b0);
        run_scan(-1, 4'b0001, 8'h80, 1'b1);
        req = 4'd0;

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
